// File: rtl/mem_req_ctrl.sv
// ---------------------------------------------------------------------------
// mem_req_ctrl
//   Initiator side of the data-memory interface. Takes one read or write
//   request at a time from the core, drives the combinational data memory
//   with a safe address/data/write-enable sequence, captures read data and
//   hands a response back to the consumer.
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_we/addr/wdata     request: 1 = write, word address, write data
//   rsp_valid/rsp_ready   response handshake (valid held until accepted)
//   rsp_rdata, rsp_err    read data (0 for writes/errors), out-of-range flag
//   mem_addr/din/we       registered drive into the data memory
//   mem_dout              combinational read data from the memory
//
// Sequence per in-range request:
//   IDLE -> SETUP (WAIT_CYC cycles) -> ACCESS (1) -> [HOLD (1), writes] -> RESP
// Out-of-range requests skip the memory entirely: IDLE -> RESP with rsp_err.
// WAIT_CYC must lie in 1..15 (the setup counter is 4 bits wide).
// ---------------------------------------------------------------------------
module mem_req_ctrl #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 8,
    parameter int WAIT_CYC  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        HOLD,
        RESP
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               op_we;
    logic               accept;
    logic               in_range;

    // Full-width compare: an address such as 8'h88 must not alias onto a
    // real word by dropping its upper bits.
    assign in_range = (int'(req_addr) < MEM_DEPTH);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = in_range ? SETUP : RESP;
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                state_nxt = op_we ? HOLD : RESP;
            end
            HOLD: begin
                state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: request latch, memory drive, response capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_we     <= 1'b0;
            cnt       <= '0;
            mem_addr  <= '0;
            mem_din   <= '0;
            mem_we    <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                op_we     <= req_we;
                rsp_rdata <= '0;
                rsp_err   <= !in_range;
                // The memory bus is only touched for legal addresses, so an
                // error response leaves mem_addr/mem_din exactly as they were.
                if (in_range) begin
                    mem_addr <= req_addr;
                    mem_din  <= req_wdata;
                    cnt      <= CNT_LOAD;
                end
            end

            if (state == SETUP && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end

            // Write enable is a one-cycle registered pulse covering ACCESS.
            // Address and data were settled during SETUP and stay put
            // through HOLD, so the address never moves while we is high.
            mem_we <= (state == SETUP) && (cnt == '0) && op_we;

            if (state == ACCESS && !op_we) begin
                rsp_rdata <= mem_dout;
            end
        end
    end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_req_ctrl
//   Two controllers (WAIT_CYC = 1 and WAIT_CYC = 4), each attached to its
//   own 8-word behavioural memory. Directed and random transactions are
//   checked against a per-transaction reference: expected read data comes
//   from a shadow memory array, expected latency from the cycle budget of
//   each operation type.
// ---------------------------------------------------------------------------
module tb_mem_req_ctrl;

    localparam int DW    = 16;
    localparam int AW    = 8;
    localparam int DEPTH = 8;
    localparam int WC0   = 1;
    localparam int WC1   = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          req_valid [2];
    logic          req_ready [2];
    logic          req_we    [2];
    logic [AW-1:0] req_addr  [2];
    logic [DW-1:0] req_wdata [2];
    logic          rsp_valid [2];
    logic          rsp_ready [2];
    logic [DW-1:0] rsp_rdata [2];
    logic          rsp_err   [2];
    logic [AW-1:0] mem_addr  [2];
    logic [DW-1:0] mem_din   [2];
    logic          mem_we    [2];
    logic [DW-1:0] mem_dout  [2];

    logic [DW-1:0] mem     [2][DEPTH];
    logic [DW-1:0] ref_mem [2][DEPTH];
    logic [AW-1:0] exp_addr [2];

    int n_chk  = 0;
    int n_fail = 0;

    mem_req_ctrl #(.DATA_W(DW), .ADDR_W(AW), .MEM_DEPTH(DEPTH), .WAIT_CYC(WC0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
        .mem_addr(mem_addr[0]), .mem_din(mem_din[0]), .mem_we(mem_we[0]),
        .mem_dout(mem_dout[0])
    );

    mem_req_ctrl #(.DATA_W(DW), .ADDR_W(AW), .MEM_DEPTH(DEPTH), .WAIT_CYC(WC1)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
        .mem_addr(mem_addr[1]), .mem_din(mem_din[1]), .mem_we(mem_we[1]),
        .mem_dout(mem_dout[1])
    );

    // Combinational memories: read follows the address, a write happens
    // whenever we is high (we rise, or addr/din change while we is high).
    assign mem_dout[0] = (mem_addr[0] < DEPTH) ? mem[0][mem_addr[0][2:0]] : '0;
    assign mem_dout[1] = (mem_addr[1] < DEPTH) ? mem[1][mem_addr[1][2:0]] : '0;

    initial begin
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < DEPTH; i++)
                mem[k][i] = DW'(32'h1001 * i + 32'h3003);
        forever begin
            @(mem_we[0] or mem_addr[0] or mem_din[0] or mem_we[1] or mem_addr[1] or mem_din[1]);
            for (int k = 0; k < 2; k++)
                if (mem_we[k] && mem_addr[k] < DEPTH)
                    mem[k][mem_addr[k][2:0]] = mem_din[k];
        end
    end

    function automatic int wc(input int k);
        return (k == 0) ? WC0 : WC1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One complete transaction on controller k, with `hold` cycles of
    // response back-pressure (0 = consumer ready before the response shows).
    task automatic txn(input int k, input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd, input int hold);
        int            n;
        int            lat;
        int            we_cyc;
        int            we_first;
        int            bus_bad;
        int            busy_bad;
        int            exp_lat;
        logic          in_rng;
        logic [DW-1:0] exp_rd;

        in_rng  = (addr < DEPTH);
        exp_rd  = (!we && in_rng) ? ref_mem[k][addr[2:0]] : '0;
        // Edges from the accept edge to the edge that raises rsp_valid;
        // an error response shows in the cycle straight after acceptance.
        exp_lat = !in_rng ? 0 : (we ? wc(k) + 2 : wc(k) + 1);

        @(negedge clk);
        req_valid[k] = 1'b1;
        req_we[k]    = we;
        req_addr[k]  = addr;
        req_wdata[k] = wd;
        rsp_ready[k] = (hold == 0);
        n = 0;
        while (!req_ready[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", 32'(n < 50), 1);
        @(negedge clk);
        req_valid[k] = 1'b0;

        lat = 0; we_cyc = 0; we_first = -1; bus_bad = 0; busy_bad = 0;
        while (!rsp_valid[k] && lat < 40) begin
            if (req_ready[k]) busy_bad++;
            if (mem_we[k]) begin
                we_cyc++;
                if (we_first < 0) we_first = lat;
            end
            if (mem_addr[k] !== (in_rng ? addr : exp_addr[k])) bus_bad++;
            if (in_rng && mem_din[k] !== wd) bus_bad++;
            @(negedge clk);
            lat++;
        end
        chk("rsp_latency", lat, exp_lat);
        chk("we_pulse_cycles", we_cyc, (we && in_rng) ? 1 : 0);
        if (we && in_rng) chk("we_after_setup", we_first, wc(k));
        chk("bus_stable", bus_bad, 0);
        chk("ready_while_busy", busy_bad, 0);
        chk("rsp_err", rsp_err[k], !in_rng);
        chk("rsp_rdata", rsp_rdata[k], exp_rd);
        chk("mem_we_in_resp", mem_we[k], 0);
        chk("ready_in_resp", req_ready[k], 0);

        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("bp_valid", rsp_valid[k], 1);
            chk("bp_rdata", rsp_rdata[k], exp_rd);
            chk("bp_ready", req_ready[k], 0);
        end
        rsp_ready[k] = 1'b1;
        @(negedge clk);
        chk("post_hs_valid", rsp_valid[k], 0);
        chk("post_hs_ready", req_ready[k], 1);
        rsp_ready[k] = 1'b0;

        if (in_rng) begin
            exp_addr[k] = addr;
            if (we) ref_mem[k][addr[2:0]] = wd;
        end
    endtask

    // Reset asserted while controller 0 is mid-write with mem_we high.
    task automatic reset_mid(input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        int n;
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = addr;
        req_wdata[0] = wd;
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        req_valid[0] = 1'b0;
        n = 0;
        while (!mem_we[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst_we_reached", mem_we[0], 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mem_we", mem_we[0], 0);
        chk("rst_rsp_valid", rsp_valid[0], 0);
        chk("rst_rsp_err", rsp_err[0], 0);
        chk("rst_rsp_rdata", rsp_rdata[0], 0);
        chk("rst_mem_addr", mem_addr[0], 0);
        chk("rst_mem_din", mem_din[0], 0);
        // The memory saw the write pulse before the abort.
        ref_mem[0][addr[2:0]] = wd;
        exp_addr[0] = '0;
        exp_addr[1] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_no_rsp", rsp_valid[0], 0);
            chk("rst_ready", req_ready[0], 1);
        end
        rsp_ready[0] = 1'b0;
    endtask

    initial begin
        logic          r_we;
        logic [AW-1:0] r_addr;
        int            r_k;

        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 1'b0;
            req_we[k]    = 1'b0;
            req_addr[k]  = '0;
            req_wdata[k] = '0;
            rsp_ready[k] = 1'b0;
            exp_addr[k]  = '0;
            for (int i = 0; i < DEPTH; i++)
                ref_mem[k][i] = DW'(32'h1001 * i + 32'h3003);
        end

        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("reset_rsp_valid", rsp_valid[k], 0);
            chk("reset_mem_we", mem_we[k], 0);
            chk("reset_mem_addr", mem_addr[k], 0);
            chk("reset_rsp_rdata", rsp_rdata[k], 0);
            chk("reset_rsp_err", rsp_err[k], 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_req_ready", req_ready[0], 1);

        // Directed: read of preloaded word, write/readback, out of range,
        // back-pressure, and the long-setup controller.
        txn(0, 1'b0, 8'd2, '0, 0);
        chk("read2_value", ref_mem[0][2], 16'h5005);
        txn(0, 1'b1, 8'd3, 16'hA5A5, 0);
        txn(0, 1'b0, 8'd3, '0, 0);
        txn(0, 1'b0, 8'h08, '0, 0);
        txn(0, 1'b1, 8'hFF, 16'h1234, 2);
        txn(0, 1'b0, 8'd3, '0, 5);
        txn(1, 1'b1, 8'd0, 16'hBEEF, 0);
        txn(1, 1'b0, 8'd0, '0, 1);
        txn(1, 1'b0, 8'h88, '0, 0);

        for (int t = 0; t < 60; t++) begin
            r_k    = int'($urandom_range(0, 1));
            r_we   = 1'($urandom_range(0, 1));
            r_addr = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(8, 255))
                                                 : AW'($urandom_range(0, 7));
            txn(r_k, r_we, r_addr, DW'($urandom), int'($urandom_range(0, 3)));
        end

        reset_mid(8'd5, 16'h7777);
        txn(0, 1'b0, 8'd5, '0, 0);

        for (int k = 0; k < 2; k++)
            for (int i = 0; i < DEPTH; i++)
                chk("final_mem", mem[k][i], ref_mem[k][i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
